gmii_tx_arbiter: RTL and testbench
==================================

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 SHALL have parameter IFG_CYCLES, default 12: number of tx_en-low cycles enforced between frames on the wire.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 7: count of 0x55 bytes before the SFD.
REQ-003 SHALL have these ports:
- clk  input  1  sole clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_tdata[i]  input  8  frame byte from source i, for i = 0,1.
- s_tvalid[i]  input  1  source i byte valid.
- s_tlast[i]  input  1  source i last byte of frame.
- s_tready[i]  output  1  source i byte accepted this cycle.
- gmii_txd  output  8  registered byte to the RGMII PHY TX path.
- gmii_tx_en  output  1  registered transmit enable.
- gmii_tx_er  output  1  registered transmit error.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse on acceptance of tlast.
- underrun  output  1  one-cycle pulse on each starved DATA cycle.

Function
REQ-004 SHALL implement states IDLE, PREAMBLE, DATA, IFG.
REQ-005 IDLE: if either s_tvalid is high, SHALL latch a grant, load gmii_txd=0x55 with gmii_tx_en=1, set preamble count to 1, and go to PREAMBLE.
REQ-006 Grant SHALL be round-robin at frame granularity.
- Both requesting: grant the source not granted last.
- One requesting: grant it.
- Last-granted register resets to 1, so source 0 wins the first contention.
REQ-007 PREAMBLE: while count < PREAMBLE_LEN, SHALL load 0x55 and increment count.
- At count == PREAMBLE_LEN, SHALL load 0xD5 (SFD) and go to DATA.
REQ-008 DATA: s_tready[grant] SHALL equal 1; s_tready of the other source and s_tready outside DATA SHALL equal 0.
REQ-009 A byte accepted in cycle N SHALL appear on gmii_txd with gmii_tx_en=1, gmii_tx_er=0 in cycle N+1.
- The first data byte immediately follows the SFD.
REQ-010 DATA with s_tvalid[grant]=0 (underrun) SHALL behave as follows:
- Next cycle drives gmii_tx_en=1, gmii_tx_er=1, gmii_txd=0x00.
- underrun pulses.
- State remains DATA; the frame resumes when valid returns.
REQ-011 On acceptance of s_tlast[grant], SHALL pulse frame_done, update last-granted, clear the IFG counter, and go to IFG.
REQ-012 IFG: gmii_tx_en, gmii_tx_er SHALL be 0 and gmii_txd SHALL be 0x00.
- After IFG_CYCLES-1 further cycles in IFG, SHALL return to IDLE.
- The wire gap is exactly IFG_CYCLES cycles of tx_en low before the next 0x55.
REQ-013 Requests arriving during PREAMBLE/DATA/IFG SHALL be held off (ready=0) and arbitrated only in IDLE.
- A request simultaneous with IFG exit is seen on the IDLE cycle.
REQ-014 Latency: s_tvalid high in IDLE at cycle 0 SHALL give the following:
- tx_en high from cycle 1.
- SFD on cycle PREAMBLE_LEN+1.
- First data accepted cycle PREAMBLE_LEN+1, on wire cycle PREAMBLE_LEN+2.
REQ-015 A single-byte frame (tvalid with tlast in the first DATA cycle) SHALL be legal and produce preamble, SFD, one byte, then IFG.
REQ-016 All gmii_* outputs SHALL be driven from flops; s_tready SHALL be combinational from state and grant only.

Reset
REQ-017 rst high SHALL asynchronously force:
- state=IDLE.
- gmii_txd=0x00, gmii_tx_en=0, gmii_tx_er=0.
- s_tready=0, busy=0, frame_done=0, underrun=0.
- Counters=0, last-granted=1.
REQ-018 Reset asserted mid-frame SHALL drop gmii_tx_en immediately, without completing the frame.
- The first post-reset frame starts with full preamble, with no IFG enforced.
REQ-019 Reset deassertion SHALL be synchronised externally; the block SHALL not begin a frame in the deassertion cycle.

Structure
REQ-020 Shared package gmii_pkg SHALL hold:
- The state enum.
- Constants GMII_PREAMBLE_BYTE=0x55 and GMII_SFD_BYTE=0xD5.
- Default IFG 12 and default preamble length 7.
REQ-021 Grant selection SHALL be a sub-module gmii_tx_rr_arb: two requests plus last-granted in, one-hot grant out, combinational.
- gmii_tx_rr_arb is reused by future multi-source MACs.

Verification
REQ-022 Bench SHALL cover these directed scenarios:
- Source 0 sends 0x11,0x22,0x33(last) from IDLE → wire shows 7×0x55, 0xD5, 11, 22, 33 on cycles 1–11, then tx_en low ≥12 cycles.
- Both sources valid simultaneously with 4-byte frames, repeated 3 frames each → order 0,1,0,1,0,1; each gap exactly 12 cycles.
- Source 1 drops tvalid for 2 cycles mid-frame → two cycles tx_er=1, txd=0x00, underrun pulses twice, frame completes intact.
- Source 1 requests during source 0 IFG → source 1 gets no ready until IDLE; its 0x55 appears exactly 12 cycles after source 0 last byte.
- rst pulsed during DATA byte 5 → tx_en=0 same cycle; new frame afterwards shows full preamble, source 0 granted.
- Single-byte frame 0xAB → 0x55×7, 0xD5, 0xAB, frame_done pulse in the accept cycle.

Source files
------------

// File: rtl/gmii_pkg.sv
// gmii_pkg: shared state type and byte constants for the GMII transmit path
package gmii_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_IFG} gmii_state_e;
  localparam logic [7:0] GMII_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] GMII_SFD_BYTE = 8'hD5;
  localparam int GMII_DEFAULT_IFG = 12;
  localparam int GMII_DEFAULT_PREAMBLE = 7;
endpackage

// File: rtl/gmii_tx_rr_arb.sv
// gmii_tx_rr_arb: two-way round-robin grant, one-hot, combinational
module gmii_tx_rr_arb (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = req[0] & (~req[1] | last_grant);
    grant[1] = req[1] & (~req[0] | ~last_grant);
  end
endmodule

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: frame-granular round-robin of two byte streams onto a GMII TX port
module gmii_tx_arbiter
  import gmii_pkg::*;
#(
  parameter int IFG_CYCLES   = GMII_DEFAULT_IFG,
  parameter int PREAMBLE_LEN = GMII_DEFAULT_PREAMBLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0][7:0] s_tdata,
  input  logic [1:0]      s_tvalid,
  input  logic [1:0]      s_tlast,
  output logic [1:0]      s_tready,
  output logic [7:0]      gmii_txd,
  output logic            gmii_tx_en,
  output logic            gmii_tx_er,
  output logic            busy,
  output logic            frame_done,
  output logic            underrun
);
  localparam int CW = $clog2((IFG_CYCLES > PREAMBLE_LEN ? IFG_CYCLES : PREAMBLE_LEN) + 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_LEN);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
  gmii_state_e state, state_n;
  logic sel, sel_n, last_sel, last_sel_n, armed;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] txd_n;
  logic en_n, er_n;
  logic [1:0] grant;
  gmii_tx_rr_arb u_arb (.req(s_tvalid), .last_grant(last_sel), .grant(grant));
  always_comb begin
    s_tready   = (state == ST_DATA) ? (sel ? 2'b10 : 2'b01) : 2'b00;
    busy       = state != ST_IDLE;
    frame_done = state == ST_DATA && s_tvalid[sel] && s_tlast[sel];
    underrun   = state == ST_DATA && !s_tvalid[sel];
  end
  always_comb begin
    state_n    = state;
    sel_n      = sel;
    last_sel_n = last_sel;
    cnt_n      = cnt;
    txd_n      = 8'h00;
    en_n       = 1'b0;
    er_n       = 1'b0;
    case (state)
      ST_IDLE: if (armed && |grant) begin
        sel_n   = grant[1];
        txd_n   = GMII_PREAMBLE_BYTE;
        en_n    = 1'b1;
        cnt_n   = CW'(1);
        state_n = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        en_n = 1'b1;
        if (cnt < PRE_LAST) begin
          txd_n = GMII_PREAMBLE_BYTE;
          cnt_n = cnt + CW'(1);
        end else begin
          txd_n   = GMII_SFD_BYTE;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        en_n = 1'b1;
        if (s_tvalid[sel]) begin
          txd_n = s_tdata[sel];
          if (s_tlast[sel]) begin
            last_sel_n = sel;
            cnt_n      = '0;
            state_n    = ST_IFG;
          end
        end else er_n = 1'b1;
      end
      ST_IFG: if (cnt == IFG_LAST) state_n = ST_IDLE; else cnt_n = cnt + CW'(1);
      default: state_n = ST_IDLE;
    endcase
  end
  // armed holds off arbitration in the first cycle after reset release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_sel   <= 1'b1;
      cnt        <= '0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      last_sel   <= last_sel_n;
      cnt        <= cnt_n;
      gmii_txd   <= txd_n;
      gmii_tx_en <= en_n;
      gmii_tx_er <= er_n;
      armed      <= 1'b1;
    end
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter: directed stimulus with a wire-byte scoreboard and grant/gap monitor
module tb_gmii_tx_arbiter;
  localparam int IFG = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][7:0] s_tdata;
  logic [1:0] s_tvalid, s_tlast, s_tready;
  logic [7:0] gmii_txd;
  logic gmii_tx_en, gmii_tx_er, busy, frame_done, underrun;
  typedef struct {logic [7:0] data; logic last; int stall;} item_t;
  typedef struct {int src; bit gap;} frm_t;
  item_t sq0[$], sq1[$];
  logic [8:0] exp_q[$];
  frm_t fq[$];
  int checks = 0, errors = 0, fd_cnt = 0, ur_cnt = 0, exp_fd = 0, exp_ur = 0;
  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .PREAMBLE_LEN(7)) dut (
    .clk(clk), .rst(rst), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
    .gmii_tx_er(gmii_tx_er), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  task automatic add_frame(input int src, input int n, input logic [7:0] base, input logic [7:0] step,
                           input int stall_at, input int stall_len, input bit gap);
    item_t it;
    frm_t f;
    repeat (7) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
    for (int j = 0; j < n; j++) begin
      it.data = base + 8'(j) * step;
      it.last = (j == n - 1);
      it.stall = (j == stall_at) ? stall_len : 0;
      for (int k = 0; k < it.stall; k++) exp_q.push_back(9'h100);
      exp_q.push_back({1'b0, it.data});
      if (src == 0) sq0.push_back(it); else sq1.push_back(it);
    end
    f.src = src;
    f.gap = gap;
    fq.push_back(f);
    exp_fd++;
    exp_ur += stall_len;
  endtask
  task automatic wait_quiet(input string name);
    bit done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = exp_q.size() == 0 && sq0.size() == 0 && sq1.size() == 0 && !busy;
    end
    chk(name, 32'(done), 1);
    repeat (15) @(negedge clk);
  endtask
  initial begin
    logic [1:0] acc;
    s_tvalid = '0;
    s_tlast = '0;
    s_tdata = '0;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      @(posedge clk);
      #1;
      if (rst) begin
        sq0.delete();
        sq1.delete();
      end else begin
        if (acc[0] && sq0.size() > 0) void'(sq0.pop_front());
        if (acc[1] && sq1.size() > 0) void'(sq1.pop_front());
      end
      s_tvalid = '0;
      s_tlast = '0;
      if (sq0.size() > 0) begin
        s_tdata[0] = sq0[0].data;
        s_tlast[0] = sq0[0].last;
        if (sq0[0].stall > 0) sq0[0].stall = sq0[0].stall - 1; else s_tvalid[0] = 1'b1;
      end
      if (sq1.size() > 0) begin
        s_tdata[1] = sq1[0].data;
        s_tlast[1] = sq1[0].last;
        if (sq1[0].stall > 0) sq1[0].stall = sq1[0].stall - 1; else s_tvalid[1] = 1'b1;
      end
    end
  end
  initial begin
    int low, cur;
    bit prev_en, have_prev;
    frm_t f;
    low = 0;
    cur = 0;
    prev_en = 0;
    have_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        fq.delete();
        have_prev = 0;
        prev_en = 0;
        low = 0;
      end else begin
        if (gmii_tx_en && !prev_en) begin
          chk("frame_expected", 32'(fq.size() > 0), 1);
          if (fq.size() > 0) begin
            f = fq.pop_front();
            cur = f.src;
            if (have_prev) begin
              if (f.gap) chk("ifg_gap", low, IFG);
              else chk("ifg_min", 32'(low >= IFG), 1);
            end
          end
        end
        if (gmii_tx_en) begin
          have_prev = 1;
          low = 0;
          chk("wire_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) chk("wire_byte", {gmii_tx_er, gmii_txd}, exp_q.pop_front());
        end else low++;
        if (|s_tready) chk("ready", s_tready, gmii_tx_en ? (cur != 0 ? 2'b10 : 2'b01) : 2'b00);
        if (frame_done || |(s_tvalid & s_tready & s_tlast))
          chk("frame_done", frame_done, |(s_tvalid & s_tready & s_tlast));
        if (frame_done) fd_cnt++;
        if (underrun) ur_cnt++;
        prev_en = gmii_tx_en;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", gmii_txd, 0);
    chk("rst_en", gmii_tx_en, 0);
    chk("rst_er", gmii_tx_er, 0);
    chk("rst_ready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      add_frame(0, 4, 8'h10 + 8'(k) * 8'h20, 8'h01, -1, 0, k > 0);
      add_frame(1, 4, 8'h80 + 8'(k) * 8'h20, 8'h01, -1, 0, 1);
    end
    wait_quiet("rr_quiet");
    add_frame(0, 3, 8'h11, 8'h11, -1, 0, 0);
    n = 0;
    while (!gmii_tx_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_latency", n, 2);
    wait_quiet("s0_quiet");
    add_frame(1, 4, 8'hC1, 8'h01, 2, 2, 0);
    wait_quiet("underrun_quiet");
    chk("underrun_cnt", ur_cnt, exp_ur);
    add_frame(0, 4, 8'h31, 8'h01, -1, 0, 0);
    n = 0;
    while (!frame_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s0_done_seen", frame_done, 1);
    repeat (3) @(negedge clk);
    add_frame(1, 2, 8'h51, 8'h01, -1, 0, 1);
    wait_quiet("holdoff_quiet");
    add_frame(0, 1, 8'hAB, 8'h00, -1, 0, 0);
    wait_quiet("single_quiet");
    chk("done_cnt", fd_cnt, exp_fd);
    add_frame(0, 8, 8'h40, 8'h01, -1, 0, 0);
    n = 0;
    while (!gmii_tx_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_start", gmii_tx_en, 1);
    repeat (11) @(negedge clk);
    chk("byte5_ready", s_tready, 2'b01);
    rst = 1'b1;
    #1;
    chk("abort_en", gmii_tx_en, 0);
    chk("abort_er", gmii_tx_er, 0);
    chk("abort_txd", gmii_txd, 0);
    chk("abort_ready", s_tready, 0);
    chk("abort_busy", busy, 0);
    exp_fd--;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    add_frame(0, 3, 8'h61, 8'h01, -1, 0, 0);
    add_frame(1, 3, 8'h71, 8'h01, -1, 0, 1);
    wait_quiet("post_rst_quiet");
    chk("final_done_cnt", fd_cnt, exp_fd);
    chk("final_underrun_cnt", ur_cnt, exp_ur);
    chk("final_exp_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
